// File: rtl/dcache_pkg.sv
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared types, field widths and helpers for the write-through
//                data cache.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RMISS = 2'd1,
      WRITE = 2'd2,
      WDONE = 2'd3
   } state_t;

   localparam int TAG_W      = 2;
   localparam int OFF_W      = 2;
   localparam int LINE_WORDS = 4;
   localparam int WORD_W     = 32;
   localparam int LINE_W     = LINE_WORDS * WORD_W;

   // Select one word of a cache line or memory block by word offset.
   function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                   input logic [OFF_W-1:0]  off);
      return line[off*WORD_W +: WORD_W];
   endfunction

   // Word offset field (lowest address bits).
   function automatic logic [OFF_W-1:0] addr_off(input logic [OFF_W-1:0] low_bits);
      return low_bits;
   endfunction

   // Block-aligned address: clear the word offset field.
   function automatic logic [OFF_W-1:0] blk_off();
      return '0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_array.sv
// ============================================================================
//  Module      : dcache_array
//  Description : Valid/tag/data storage for a direct-mapped cache with a
//                combinational lookup, a line-fill port and a word-update port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_array
   import dcache_pkg::*;
#(
   parameter int IDX_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   // lookup
   input  logic [IDX_W-1:0]  lk_idx,
   input  logic [TAG_W-1:0]  lk_tag,
   input  logic [OFF_W-1:0]  lk_off,
   output logic              hit,
   output logic [WORD_W-1:0] word,
   // whole-line fill
   input  logic              fill_en,
   input  logic [IDX_W-1:0]  fill_idx,
   input  logic [TAG_W-1:0]  fill_tag,
   input  logic [LINE_W-1:0] fill_line,
   // single-word update
   input  logic              upd_en,
   input  logic [IDX_W-1:0]  upd_idx,
   input  logic [OFF_W-1:0]  upd_off,
   input  logic [WORD_W-1:0] upd_word
);

   localparam int LINES = 1 << IDX_W;

   logic [LINES-1:0]  valid;
   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [LINE_W-1:0] data_mem [LINES];

   // Valid bits are the only reset state: clearing them discards any partial fill.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
      end else if (fill_en) begin
         valid[fill_idx] <= 1'b1;
      end
   end

   // Tag and data storage; contents are meaningless until the valid bit is set.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_mem[fill_idx]  <= fill_tag;
         data_mem[fill_idx] <= fill_line;
      end else if (upd_en) begin
         data_mem[upd_idx][upd_off*WORD_W +: WORD_W] <= upd_word;
      end
   end

   // Combinational lookup of the addressed line.
   always_comb begin
      hit  = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
      word = line_word(data_mem[lk_idx], lk_off);
   end

endmodule

`default_nettype wire

// File: rtl/dcache_wt.sv
// ============================================================================
//  Module      : dcache_wt
//  Description : Direct-mapped, write-through, no-write-allocate data cache
//                with saturating read hit/miss counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_wt
   import dcache_pkg::*;
#(
   parameter int IDX_W = 3,
   parameter int CNT_W = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           proc_CEN,
   input  logic                           proc_WEN,
   input  logic                           proc_OEN,
   input  logic [TAG_W+IDX_W+OFF_W-1:0]   proc_A,
   input  logic [WORD_W-1:0]              proc_wdata,
   output logic [WORD_W-1:0]              proc_rdata,
   output logic                           proc_stall,
   output logic                           mem_read,
   output logic                           mem_write,
   output logic [TAG_W+IDX_W+OFF_W-1:0]   mem_addr,
   output logic [WORD_W-1:0]              mem_wdata,
   input  logic [LINE_W-1:0]              mem_rdata,
   input  logic                           mem_ready,
   output logic [CNT_W-1:0]               hit_cnt,
   output logic [CNT_W-1:0]               miss_cnt
);

   localparam int ADDR_W = TAG_W + IDX_W + OFF_W;

   state_t              state;
   state_t              state_nx;
   logic                req_wr;
   logic                req_rd;
   logic [TAG_W-1:0]    a_tag;
   logic [IDX_W-1:0]    a_idx;
   logic [OFF_W-1:0]    a_off;
   logic                lk_hit;
   logic [WORD_W-1:0]   lk_word;
   logic                hit_ev;
   logic                miss_ev;
   logic                fill_en;
   logic                upd_en;

   // A store wins over a load when both enables are low.
   assign req_wr = !proc_CEN && !proc_WEN;
   assign req_rd = !proc_CEN &&  proc_WEN && !proc_OEN;
   assign a_tag  = proc_A[ADDR_W-1 -: TAG_W];
   assign a_idx  = proc_A[OFF_W +: IDX_W];
   assign a_off  = addr_off(proc_A[OFF_W-1:0]);

   dcache_array #(
      .IDX_W (IDX_W)
   ) u_array (
      .clk       (clk),
      .rst       (rst),
      .lk_idx    (a_idx),
      .lk_tag    (a_tag),
      .lk_off    (a_off),
      .hit       (lk_hit),
      .word      (lk_word),
      .fill_en   (fill_en),
      .fill_idx  (a_idx),
      .fill_tag  (a_tag),
      .fill_line (mem_rdata),
      .upd_en    (upd_en),
      .upd_idx   (a_idx),
      .upd_off   (a_off),
      .upd_word  (proc_wdata)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state, processor-side outputs and array write strobes.
   always_comb begin
      state_nx   = state;
      proc_stall = 1'b0;
      proc_rdata = '0;
      hit_ev     = 1'b0;
      miss_ev    = 1'b0;
      fill_en    = 1'b0;
      upd_en     = 1'b0;
      case (state)
         IDLE: begin
            if (req_wr) begin
               proc_stall = 1'b1;
               state_nx   = WRITE;
            end else if (req_rd) begin
               if (lk_hit) begin
                  proc_rdata = lk_word;
                  hit_ev     = 1'b1;
               end else begin
                  proc_stall = 1'b1;
                  miss_ev    = 1'b1;
                  state_nx   = RMISS;
               end
            end
         end
         RMISS: begin
            proc_stall = 1'b1;
            if (mem_ready) begin
               fill_en  = 1'b1;
               state_nx = IDLE;
            end
         end
         WRITE: begin
            proc_stall = 1'b1;
            if (mem_ready) begin
               upd_en   = lk_hit;
               state_nx = WDONE;
            end
         end
         // WDONE lets the processor retire the store without reissuing it.
         WDONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Registered memory interface, launched on leaving IDLE and dropped on ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_wr) begin
                  mem_write <= 1'b1;
                  mem_addr  <= proc_A;
                  mem_wdata <= proc_wdata;
               end else if (req_rd && !lk_hit) begin
                  mem_read  <= 1'b1;
                  mem_addr  <= {a_tag, a_idx, blk_off()};
               end
            end
            RMISS:   if (mem_ready) mem_read  <= 1'b0;
            WRITE:   if (mem_ready) mem_write <= 1'b0;
            default: ;
         endcase
      end
   end

   // Saturating read hit/miss counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (hit_ev  && (hit_cnt  != '1)) hit_cnt  <= hit_cnt  + 1'b1;
         if (miss_ev && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dcache_wt.sv
// ============================================================================
//  Module      : tb_dcache_wt
//  Description : Scoreboard bench for dcache_wt with a backing-memory responder
//                and a reference model of cache contents and counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_wt;

   localparam int CW = 4;   // narrow counters so saturation is reached

   logic          clk, rst;
   logic          proc_CEN, proc_WEN, proc_OEN;
   logic [6:0]    proc_A;
   logic [31:0]   proc_wdata, proc_rdata;
   logic          proc_stall, mem_read, mem_write;
   logic [6:0]    mem_addr;
   logic [31:0]   mem_wdata;
   logic [127:0]  mem_rdata;
   logic          mem_ready;
   logic [CW-1:0] hit_cnt, miss_cnt;

   dcache_wt #(.IDX_W(3), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .proc_CEN(proc_CEN), .proc_WEN(proc_WEN), .proc_OEN(proc_OEN),
      .proc_A(proc_A), .proc_wdata(proc_wdata), .proc_rdata(proc_rdata),
      .proc_stall(proc_stall), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // backing memory (environment) and reference-model state
   logic [31:0] bmem    [128];
   logic [31:0] ref_mem [128];
   bit          m_valid [8];
   logic [1:0]  m_tag   [8];
   int          m_hit, m_miss;

   // scoreboard queues
   logic [31:0] dq [$];   // expected load data, in retirement order
   logic [6:0]  rq [$];   // expected block-read addresses
   logic [38:0] wq [$];   // expected {addr,data} memory writes

   bit hold_ready = 1'b0;
   int dly = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > (1 << CW) - 1) ? (1 << CW) - 1 : v;
   endfunction

   // Memory responder: one-cycle ready pulse after a random delay.
   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (rst || hold_ready || mem_ready) begin
            mem_ready = 1'b0;
         end else if (mem_read || mem_write) begin
            if (dly == 0) begin
               mem_ready = 1'b1;
               if (mem_read)
                  for (int k = 0; k < 4; k++)
                     mem_rdata[32*k +: 32] = bmem[int'({mem_addr[6:2], 2'b00}) + k];
               if (mem_write) bmem[mem_addr] = mem_wdata;
               dly = $urandom_range(0, 2);
            end else begin
               dly--;
            end
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a result.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (!proc_CEN && proc_WEN && !proc_OEN && !proc_stall) begin
               if (dq.size() == 0) chk("unexpected_load", 1, 0);
               else chk("load_data", proc_rdata, dq.pop_front());
            end
            if (mem_read && mem_ready) begin
               if (rq.size() == 0) chk("unexpected_mem_read", 1, 0);
               else chk("mem_read_addr", mem_addr, rq.pop_front());
            end
            if (mem_write && mem_ready) begin
               if (wq.size() == 0) chk("unexpected_mem_write", 1, 0);
               else chk("mem_write_addr_data", {mem_addr, mem_wdata}, wq.pop_front());
            end
         end
      end
   end

   // Issue one processor request (called #1 after a rising edge) and hold it until retired.
   task automatic do_op(input bit wr, input logic [6:0] a, input logic [31:0] d);
      int         waits;
      bit         hit;
      logic [2:0] ix;
      logic [1:0] tg;
      ix  = a[4:2];
      tg  = a[6:5];
      hit = 1'b0;
      if (wr) begin
         wq.push_back({a, d});
         ref_mem[a] = d;
      end else begin
         hit = m_valid[ix] && (m_tag[ix] == tg);
         if (!hit) begin
            rq.push_back({a[6:2], 2'b00});
            m_valid[ix] = 1'b1;
            m_tag[ix]   = tg;
            m_miss++;
         end
         m_hit++;   // a refilled load also hits on retirement
         dq.push_back(ref_mem[a]);
      end
      proc_A     = a;
      proc_wdata = d;
      proc_WEN   = !wr;
      proc_OEN   = wr ? 1'($urandom_range(0, 1)) : 1'b0;
      proc_CEN   = 1'b0;
      waits      = 0;
      forever begin
         @(negedge clk);
         if (!proc_stall || waits > 60) break;
         waits++;
         @(posedge clk); #1;
      end
      if (waits > 60)  chk("request_timeout", waits, 0);
      else if (wr)     chk("store_stall_ge2", (waits >= 2), 1);
      else             chk("hit_zero_latency", (waits == 0), hit);
      @(posedge clk); #1;
      proc_CEN = 1'b1;
      proc_WEN = 1'b1;
      proc_OEN = 1'b1;
   endtask

   task automatic chk_cnt(input string tag);
      chk({tag, "_hit_cnt"},  hit_cnt,  sat(m_hit));
      chk({tag, "_miss_cnt"}, miss_cnt, sat(m_miss));
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      m_hit  = 0;
      m_miss = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      proc_CEN = 1'b1; proc_WEN = 1'b1; proc_OEN = 1'b1;
      proc_A = '0; proc_wdata = '0;
      for (int i = 0; i < 128; i++) begin
         bmem[i]    = $urandom;
         ref_mem[i] = bmem[i];
      end
      for (int k = 0; k < 4; k++) begin
         bmem[4 + k]    = 32'(k + 1);
         ref_mem[4 + k] = 32'(k + 1);
      end
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_stall", proc_stall, 0);
      chk("reset_mem_rw", {mem_read, mem_write}, 0);
      chk("reset_mem_addr_wdata", {mem_addr, mem_wdata}, 0);
      chk("reset_rdata", proc_rdata, 0);
      chk_cnt("reset");
      @(posedge clk); #1;

      // directed sequence
      do_op(0, 7'h05, 0);            // miss, block {4,3,2,1}, word 1 -> 2
      chk_cnt("first_miss");
      do_op(0, 7'h06, 0);            // hit -> 3
      chk_cnt("second_hit");
      do_op(1, 7'h05, 32'hAB);       // store hit
      do_op(0, 7'h05, 0);            // hit returns AB
      chk_cnt("after_store");
      do_op(0, 7'h25, 0);            // same index, tag 01: evict
      do_op(0, 7'h05, 0);            // misses again
      chk_cnt("after_evict");
      do_op(1, 7'h40, 32'h1234_5678); // store to invalid line, no allocate
      do_op(0, 7'h40, 0);            // must miss
      chk_cnt("no_alloc");

      // reset in the middle of a refill
      hold_ready = 1'b1;
      proc_A = 7'h11; proc_WEN = 1'b1; proc_OEN = 1'b0; proc_CEN = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rmiss_mem_read", mem_read, 1);
      #2 rst = 1'b1;
      #1;
      chk("abort_mem_read", mem_read, 0);
      chk("abort_counters", {hit_cnt, miss_cnt}, 0);
      proc_CEN = 1'b1; proc_OEN = 1'b1;
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      hold_ready = 1'b0;
      @(posedge clk); #1;
      do_op(0, 7'h11, 0);            // fill was discarded: misses
      do_op(0, 7'h05, 0);            // all lines invalidated: misses
      chk_cnt("after_abort");

      // randomized traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         logic [6:0] a;
         a = 7'($urandom_range(0, 127));
         if ($urandom_range(0, 9) < 3) do_op(1, a, $urandom);
         else                          do_op(0, a, 0);
         if ($urandom_range(0, 7) == 0) begin
            @(posedge clk); #1;
         end
      end
      chk_cnt("random_saturated");

      repeat (4) @(posedge clk);
      chk("load_queue_empty", dq.size(), 0);
      chk("read_queue_empty", rq.size(), 0);
      chk("write_queue_empty", wq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dcache_wt.md
# dcache_wt

Direct-mapped, write-through, no-write-allocate data cache that sits between the single-cycle MIPS datapath's data-memory port and a slow block-oriented data memory. Read hits return data in the same cycle with no stall. Misses and all stores raise `proc_stall` until the memory handshake completes. Two saturating counters record hits and misses for performance runs.

## Interface
- `IDX_W`, default 3: index bits (8 lines).
- `CNT_W`, default 16: width of the hit and miss counters.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `proc_CEN` in 1: request enable, active-low.
- `proc_WEN` in 1: write enable, active-low.
- `proc_OEN` in 1: read enable, active-low.
- `proc_A` in 7: word address. Split as tag[6:5], index[4:2], offset[1:0].
- `proc_wdata` in 32: store data.
- `proc_rdata` out 32: load data.
- `proc_stall` out 1: processor must hold its request and PC while this is high.
- `mem_read` out 1: block read request, held until `mem_ready`.
- `mem_write` out 1: word write request, held until `mem_ready`.
- `mem_addr` out 7: for a read, the block address {tag,index,2'b00}; for a write, the word address.
- `mem_wdata` out 32: word to be written.
- `mem_rdata` in 128: returned block; word k is at bits [32k+31:32k].
- `mem_ready` in 1: one-cycle completion pulse.
- `hit_cnt` out CNT_W: saturating read-hit count.
- `miss_cnt` out CNT_W: saturating read-miss count.

## Operation
- Request decode:
  - A request is active when `proc_CEN`=0.
  - It is a write if `proc_WEN`=0; a write takes priority even when `proc_OEN`=0 at the same time.
  - It is a read if `proc_WEN`=1 and `proc_OEN`=0.
  - `proc_CEN`=1 means idle: `proc_stall`=0 and the memory interface is inactive.
- States: IDLE, RMISS, WRITE, WDONE.
- IDLE, read hit (valid line and tag match):
  - `proc_rdata` is the selected word, combinationally.
  - `proc_stall`=0.
  - `hit_cnt`+1 at the clock edge.
- IDLE, read miss:
  - `proc_stall`=1 combinationally.
  - `miss_cnt`+1.
  - Next state RMISS.
- RMISS:
  - `mem_read`=1, `mem_addr`={tag,index,00}, `proc_stall`=1.
  - On `mem_ready`: write all 4 words, the tag and valid=1 into the line, then go to IDLE.
  - The held request then hits in IDLE. That hit counts in `hit_cnt`.
- IDLE, write: `proc_stall`=1; next state WRITE.
- WRITE:
  - `mem_write`=1, `mem_addr`=`proc_A`, `mem_wdata`=`proc_wdata`, `proc_stall`=1.
  - On `mem_ready`: if the line hits, update that word in the cache; if it misses, leave the cache unchanged.
  - Next state WDONE.
- WDONE:
  - `proc_stall`=0 so the processor retires the store.
  - No memory activity and no cache update; next state IDLE.
  - This state prevents the held store from being issued twice.
- `mem_ready` is ignored in IDLE and WDONE.
- Counters saturate at all-ones and do not wrap.
- A write never allocates a line and never counts as a hit or miss.

## Timing
- Reset values:
  - state IDLE; all valid bits 0.
  - `proc_stall`=0 when idle.
  - `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
  - `proc_rdata`=0, `hit_cnt`=0, `miss_cnt`=0.
  - Tag and data arrays are not reset.
- Read hit: 0-cycle latency.
- Read miss: stall from cycle 0, `mem_read` from cycle 1. If `mem_ready` arrives in cycle n, data is returned in cycle n+1 with stall=0.
- Store: stall cycles 0..n, with `mem_ready` in cycle n. WDONE is cycle n+1 with stall=0.
- `mem_*` outputs are registered from the state and change only at clock edges.
- Reset asserted mid-transaction aborts it immediately (asynchronously): `mem_read`/`mem_write` drop, all lines are invalidated, and a partial fill is discarded.
- Processor request changing while `proc_stall`=1 is a protocol violation; behaviour is undefined.

## Structure
- Package `dcache_pkg`:
  - state enum (IDLE, RMISS, WRITE, WDONE).
  - TAG_W=2, OFF_W=2, LINE_WORDS=4.
  - Address-field slice helpers.
- Sub-module `dcache_array`: holds the valid, tag and data storage. It provides a combinational lookup (hit flag and word out), a line-fill write port and a word-update write port.
- The top level holds the FSM, the counters and the memory interface.

## Test plan
- Reset, then read A=7'h05 with `mem_ready` in cycle 3 and block {D3,D2,D1,D0}={4,3,2,1} → stall in cycles 0-3, `mem_addr`=7'h04, `proc_rdata`=2 in cycle 4, miss_cnt=1, hit_cnt=1.
- Then read A=7'h06 → `proc_rdata`=3 in the same cycle, stall=0, hit_cnt=2.
- Write A=7'h05 with data 32'hAB (hit), `mem_ready` after 2 cycles → `mem_write` pulse sequence as specified, WDONE stall=0, exactly one memory write; a following read of 7'h05 returns 32'hAB with no miss.
- Read A=7'h25 (same index, tag 01) → miss and refill; a subsequent read of 7'h05 misses again (eviction), miss_cnt increases by 2.
- Write A=7'h40 on an invalid line → memory written, cache unchanged, a following read of 7'h40 misses.
- Assert `rst` during RMISS before `mem_ready` → `mem_read`=0 immediately, counters=0, the next read misses.
